tlu_trigger_input_conditioner: RTL

Upstream front end of the TLU controller, in the TRIGGER_CLK domain. It synchronises the raw asynchronous trigger and veto inputs, then applies per-channel polarity inversion, a programmable digital glitch filter and an enable mask. It drives the TRIGGER / TRIGGER_VETO inputs of the TLU controller and also provides per-channel rising-edge pulses and saturating edge counters for rate monitoring.

---
 rtl/tlu_trigger_pkg.sv | 16 +
 rtl/tlu_trigger_filter_channel.sv | 48 ++++
 rtl/tlu_trigger_input_conditioner.sv | 83 ++++++++
 3 files changed

// File: rtl/tlu_trigger_pkg.sv
// Shared defaults and helpers for the TLU trigger input conditioner.
package tlu_trigger_pkg;

  localparam int DEF_CHANNELS      = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_WIDTH  = 4;
  localparam int DEF_COUNTER_WIDTH = 32;

  // All-ones source for edge-counter saturation; sliced to the counter width (max 64).
  localparam logic [63:0] CNT_SAT_ALL = '1;

  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/tlu_trigger_filter_channel.sv
// One trigger channel: synchroniser, polarity inversion, glitch filter and rise detect.
module tlu_trigger_filter_channel #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_trig,
  input  logic                    i_invert,
  input  logic                    i_enable,
  input  logic [FILTER_WIDTH-1:0] i_filter_len,
  output logic                    o_trig,
  output logic                    o_rise
);

  logic [SYNC_STAGES-1:0]  r_sync;
  logic [FILTER_WIDTH-1:0] r_cnt;
  logic                    r_filt;
  logic                    r_filt_d;
  logic                    w_raw;

  assign w_raw = r_sync[SYNC_STAGES-1] ^ i_invert;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_trig};
      r_filt_d <= r_filt;
      // >= keeps a shortened filter length from stranding a counter above it
      if (w_raw == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_filter_len) begin
        r_filt <= w_raw;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + FILTER_WIDTH'(1);
      end
    end
  end

  assign o_trig = r_filt & i_enable;
  assign o_rise = r_filt & ~r_filt_d & i_enable;

endmodule

// File: rtl/tlu_trigger_input_conditioner.sv
// TLU trigger front end: per-channel filtered triggers, synchronised vetoes and edge counters.
module tlu_trigger_input_conditioner
  import tlu_trigger_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_WIDTH  = DEF_FILTER_WIDTH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic                             TRIGGER_CLK,
  input  logic                             TRIGGER_RST_N,
  input  logic [CHANNELS-1:0]              TRIGGER_IN,
  input  logic [CHANNELS-1:0]              VETO_IN,
  input  logic [CHANNELS-1:0]              INVERT,
  input  logic [CHANNELS-1:0]              ENABLE_MASK,
  input  logic [FILTER_WIDTH-1:0]          FILTER_LEN,
  input  logic [sel_width(CHANNELS)-1:0]   COUNT_SEL,
  input  logic                             COUNT_CLEAR,
  output logic [CHANNELS-1:0]              TRIGGER,
  output logic [CHANNELS-1:0]              TRIGGER_VETO,
  output logic [CHANNELS-1:0]              TRIGGER_RISE,
  output logic                             ANY_TRIGGER,
  output logic [COUNTER_WIDTH-1:0]         COUNT_OUT
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_SAT = CNT_SAT_ALL[COUNTER_WIDTH-1:0];

  logic [CHANNELS-1:0]      w_trig;
  logic [CHANNELS-1:0]      w_rise;
  logic [CHANNELS-1:0]      r_veto_sync [SYNC_STAGES];
  logic [COUNTER_WIDTH-1:0] r_edge_cnt  [CHANNELS];
  logic [COUNTER_WIDTH-1:0] r_count_out;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    tlu_trigger_filter_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_WIDTH (FILTER_WIDTH)
    ) u_ch (
      .i_clk        (TRIGGER_CLK),
      .i_rst_n      (TRIGGER_RST_N),
      .i_trig       (TRIGGER_IN[g]),
      .i_invert     (INVERT[g]),
      .i_enable     (ENABLE_MASK[g]),
      .i_filter_len (FILTER_LEN),
      .o_trig       (w_trig[g]),
      .o_rise       (w_rise[g])
    );
  end

  always_ff @(posedge TRIGGER_CLK or negedge TRIGGER_RST_N) begin
    if (!TRIGGER_RST_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_veto_sync[s] <= '0;
    end else begin
      r_veto_sync[0] <= VETO_IN;
      for (int s = 1; s < SYNC_STAGES; s++) r_veto_sync[s] <= r_veto_sync[s-1];
    end
  end

  // Clear takes priority over a coincident rise; counters hold at all-ones.
  always_ff @(posedge TRIGGER_CLK or negedge TRIGGER_RST_N) begin
    if (!TRIGGER_RST_N) begin
      for (int i = 0; i < CHANNELS; i++) r_edge_cnt[i] <= '0;
      r_count_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (COUNT_CLEAR) begin
          r_edge_cnt[i] <= '0;
        end else if (w_rise[i] && (r_edge_cnt[i] != CNT_SAT)) begin
          r_edge_cnt[i] <= r_edge_cnt[i] + COUNTER_WIDTH'(1);
        end
      end
      if (int'(COUNT_SEL) < CHANNELS) r_count_out <= r_edge_cnt[COUNT_SEL];
      else                            r_count_out <= '0;
    end
  end

  assign TRIGGER      = w_trig;
  assign TRIGGER_RISE = w_rise;
  assign ANY_TRIGGER  = |w_trig;
  assign TRIGGER_VETO = r_veto_sync[SYNC_STAGES-1];
  assign COUNT_OUT    = r_count_out;

endmodule
